fpdiv: RTL and testbench
========================

# fpdiv

Iterative single-precision (IEEE-754 binary32) floating-point divider computing Q = A / B, built as a companion to FPMUL in the arithmetic datapath. It uses the same Start/Done request–response handshake and the same flag set as FPMUL, so the existing benches and sequencers can drive either unit. The mantissa quotient comes from a restoring divider that produces one bit per clock.

## Interface
- No parameters; the format is fixed at binary32.
- Clk  in  1  Single clock; all state updates on the rising edge.
- Rst  in  1  Asynchronous, active-high reset.
- Start  in  1  Request. Sampled only in IDLE or FIN.
- A  in  32  Dividend. Captured on the edge that accepts Start.
- B  in  32  Divisor. Captured on the same edge.
- Done  out  1  High while in FIN. Q and all flags are valid and stable while Done is high.
- Q  out  32  Quotient.
- OF  out  1  Overflow: result forced to signed infinity.
- UF  out  1  Underflow: result flushed to signed zero.
- NaNF  out  1  Result is NaN.
- InfF  out  1  Result is ±infinity.
- DNF  out  1  An operand was denormal and was flushed to zero.
- ZF  out  1  Result is ±zero.

## Operation
- Reset values: state=IDLE, Done=0, Q=0, all flags 0.
- States and transitions:
  - IDLE → UNPACK on Start.
  - UNPACK → DIV for finite non-zero operands; UNPACK → FIN for special operands.
  - DIV runs 26 iterations, then → NORM.
  - NORM → ROUND → FIN.
  - FIN holds until Start is seen, then → UNPACK.
- Start is ignored in UNPACK, DIV, NORM and ROUND.
- UNPACK:
  - Sign = sA ^ sB.
  - Denormal operands (exp=0, frac≠0) are treated as zero and set DNF.
  - Exponent ediff = eA − eB + 127, held in a 10-bit signed register.
- Special cases, resolved in UNPACK with priority top-down:
  - Either operand NaN, 0/0, or Inf/Inf → Q=32'hFFFF_FFFF, NaNF=1.
  - Inf/finite, or nonzero/0 → Q={sign, 8'hFF, 23'h0}, InfF=1.
  - 0/nonzero, or finite/Inf → Q={sign, 31'h0}, ZF=1.
- DIV:
  - Remainder is initialised to {1,fracA}; divisor is {1,fracB} (24 bits each).
  - Each cycle: trial subtract. If it does not go negative, keep the difference and shift in 1; otherwise restore and shift in 0. Then shift the remainder left by 1.
  - After 26 cycles the 26-bit quotient q[25:0] is complete.
  - Sticky = (remainder ≠ 0).
- NORM:
  - If q[25]=0, shift q left by 1 and decrement ediff.
  - The mantissa is then q[25:2], guard = q[1], and round/sticky = q[0] | sticky.
- ROUND:
  - Apply the rounding per Configuration.
  - A mantissa carry-out renormalises and increments ediff.
  - ediff ≥ 255 → Inf, OF=1, InfF=1.
  - ediff ≤ 0 → signed zero, UF=1, ZF=1. No denormal results are produced.
- DNF is retained alongside any of the above results.
- On accepting a new Start, all flags clear.

## Timing
- Normal path: Start is accepted at edge 0.
  - UNPACK completes at edge 1.
  - DIV iterations happen at edges 2–27.
  - NORM at edge 28, ROUND at edge 29.
  - Done=1 from edge 29, i.e. 29-cycle latency.
- Special path: Done=1 from edge 1.
- Back-to-back operation: Start held high in FIN is accepted on the next edge. Done drops on that edge.
- Reset asserted mid-operation returns the block immediately to IDLE with all outputs zero. Operands in flight are discarded.

## Configuration
- FPDIV_RNE_EN defined: round-to-nearest-even.
  - Increment when guard & (round_sticky | lsb).
- FPDIV_RNE_EN undefined: truncation (round toward zero).
  - Guard and sticky are ignored; the ROUND state is still present so latency is identical.

## Structure
- Package fpdiv_pkg holds:
  - State enum: IDLE, UNPACK, DIV, NORM, ROUND, FIN.
  - Constants: EXP_BIAS=127, EXP_MAX=255, MANT_W=24, QBITS=26, QNAN=32'hFFFF_FFFF.
- Sub-module fpdiv_classify: combinational per-operand decode producing sign, exponent, mantissa with hidden bit, and is_zero/is_inf/is_nan/is_denorm. It is instantiated twice, once for A and once for B.

## Test plan
- 40C00000 / 40000000 (6/2) → Q=40400000, flags 0, Done after 29 cycles.
- 3F800000 / 40400000 (1/3) → Q=3EAAAAAB with FPDIV_RNE_EN, 3EAAAAAA without it.
- 00000000 / 00000000 → Q=FFFFFFFF, NaNF=1, Done after 1 cycle. 3F800000 / 80000000 → Q=FF800000, InfF=1.
- 7F000000 / 3E800000 → Q=7F800000, OF=InfF=1. 00800000 / 40000000 → Q=00000000, UF=ZF=1.
- 00000001 / 3F800000 → Q=00000000, DNF=ZF=1.
- Two checks in one run:
  - Start pulsed again during DIV is ignored, and the first result is unchanged.
  - Rst asserted at DIV cycle 10 gives all outputs 0 and state IDLE; a subsequent 6/2 still returns 40400000.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared constants, state encodings and small helpers for the binary32 divider.
// The FPDIV_RNE_EN macro (consumed in fpdiv.sv) selects round-to-nearest-even over truncation.
package fpdiv_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 24;
    localparam int QBITS    = 26;
    localparam logic [31:0] QNAN = 32'hFFFF_FFFF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_DIV    = 3'd2;
    localparam logic [2:0] ST_NORM   = 3'd3;
    localparam logic [2:0] ST_ROUND  = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    typedef struct packed {
        logic of;
        logic uf;
        logic nanf;
        logic inff;
        logic dnf;
        logic zf;
    } flags_t;

    function automatic logic [31:0] signed_inf(input logic s);
        return {s, 8'hFF, 23'h0};
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return {s, 31'h0};
    endfunction

endpackage

// File: rtl/fpdiv_classify.sv
// Combinational binary32 operand decode: fields, hidden bit and class flags.
// Denormals report is_zero as well, since the divider flushes them.
module fpdiv_classify
    import fpdiv_pkg::*;
(
    input  logic [31:0]       i_op,
    output logic              o_sign,
    output logic [7:0]        o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan,
    output logic              o_is_denorm
);

    logic w_exp_zero;
    logic w_exp_ones;
    logic w_frac_zero;

    assign w_exp_zero  = (i_op[30:23] == 8'h00);
    assign w_exp_ones  = (i_op[30:23] == 8'hFF);
    assign w_frac_zero = (i_op[22:0] == 23'h0);

    assign o_sign      = i_op[31];
    assign o_exp       = i_op[30:23];
    assign o_mant      = {~w_exp_zero, i_op[22:0]};
    assign o_is_zero   = w_exp_zero;
    assign o_is_denorm = w_exp_zero & ~w_frac_zero;
    assign o_is_inf    = w_exp_ones & w_frac_zero;
    assign o_is_nan    = w_exp_ones & ~w_frac_zero;

endmodule

// File: rtl/fpdiv.sv
// Iterative binary32 divider Q = A / B, one restoring quotient bit per clock.
// Define FPDIV_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpdiv
    import fpdiv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_done,
    output logic [31:0] o_q,
    output logic        o_of,
    output logic        o_uf,
    output logic        o_nanf,
    output logic        o_inff,
    output logic        o_dnf,
    output logic        o_zf
);

    localparam logic signed [9:0] L_EMAX = 10'(EXP_MAX);

    logic [2:0]        r_state;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_sign;
    logic signed [9:0] r_ediff;
    logic [MANT_W:0]   r_rem;
    logic [MANT_W-1:0] r_div;
    logic [QBITS-1:0]  r_quo;
    logic [4:0]        r_cnt;
    logic [MANT_W-1:0] r_mant;
    logic [31:0]       r_q;
    flags_t            r_flags;
`ifdef FPDIV_RNE_EN
    logic              r_guard;
    logic              r_rs;
`endif

    logic              w_a_sign, w_b_sign;
    logic [7:0]        w_a_exp, w_b_exp;
    logic [MANT_W-1:0] w_a_mant, w_b_mant;
    logic              w_a_zero, w_a_inf, w_a_nan, w_a_den;
    logic              w_b_zero, w_b_inf, w_b_nan, w_b_den;

    fpdiv_classify u_cls_a (
        .i_op        (r_a),
        .o_sign      (w_a_sign),
        .o_exp       (w_a_exp),
        .o_mant      (w_a_mant),
        .o_is_zero   (w_a_zero),
        .o_is_inf    (w_a_inf),
        .o_is_nan    (w_a_nan),
        .o_is_denorm (w_a_den)
    );

    fpdiv_classify u_cls_b (
        .i_op        (r_b),
        .o_sign      (w_b_sign),
        .o_exp       (w_b_exp),
        .o_mant      (w_b_mant),
        .o_is_zero   (w_b_zero),
        .o_is_inf    (w_b_inf),
        .o_is_nan    (w_b_nan),
        .o_is_denorm (w_b_den)
    );

    logic              w_sign;
    logic              w_nan_case, w_inf_case, w_zero_case;
    logic [9:0]        w_ediff0;
    logic [MANT_W+1:0] w_trial;
    logic              w_trial_neg;
    logic [MANT_W:0]   w_rem_next;
    logic [QBITS-1:0]  w_qn;
    logic              w_inc;
    logic [MANT_W:0]   w_mant_sum;
    logic [MANT_W-1:0] w_mant_fin;
    logic signed [9:0] w_e_rnd;
    logic              w_accept;

    assign w_sign      = w_a_sign ^ w_b_sign;
    // Priority is encoded by the if/else order in UNPACK; these are raw conditions.
    assign w_nan_case  = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_inf_case  = w_a_inf | w_b_zero;
    assign w_zero_case = w_a_zero | w_b_inf;
    assign w_ediff0    = {2'b00, w_a_exp} - {2'b00, w_b_exp} + 10'(EXP_BIAS);

    assign w_trial     = {1'b0, r_rem} - {2'b00, r_div};
    assign w_trial_neg = w_trial[MANT_W+1];
    assign w_rem_next  = w_trial_neg ? r_rem : w_trial[MANT_W:0];

    assign w_qn        = r_quo[QBITS-1] ? r_quo : {r_quo[QBITS-2:0], 1'b0};

`ifdef FPDIV_RNE_EN
    assign w_inc = r_guard & (r_rs | r_mant[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign w_mant_sum = {1'b0, r_mant} + {{MANT_W{1'b0}}, w_inc};
    assign w_mant_fin = w_mant_sum[MANT_W] ? w_mant_sum[MANT_W:1] : w_mant_sum[MANT_W-1:0];
    assign w_e_rnd    = r_ediff + $signed({9'b0, w_mant_sum[MANT_W]});

    assign w_accept = i_start & ((r_state == ST_IDLE) | (r_state == ST_FIN));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_ediff <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_mant  <= '0;
            r_q     <= '0;
            r_flags <= '0;
`ifdef FPDIV_RNE_EN
            r_guard <= 1'b0;
            r_rs    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_q     <= '0;
            r_flags <= '0;
            r_state <= ST_UNPACK;
        end else begin
            case (r_state)
                ST_UNPACK: begin
                    r_sign      <= w_sign;
                    r_flags.dnf <= w_a_den | w_b_den;
                    if (w_nan_case) begin
                        r_q          <= QNAN;
                        r_flags.nanf <= 1'b1;
                        r_state      <= ST_FIN;
                    end else if (w_inf_case) begin
                        r_q          <= signed_inf(w_sign);
                        r_flags.inff <= 1'b1;
                        r_state      <= ST_FIN;
                    end else if (w_zero_case) begin
                        r_q        <= signed_zero(w_sign);
                        r_flags.zf <= 1'b1;
                        r_state    <= ST_FIN;
                    end else begin
                        r_rem   <= {1'b0, w_a_mant};
                        r_div   <= w_b_mant;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        r_ediff <= $signed(w_ediff0);
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_next << 1;
                    r_quo <= {r_quo[QBITS-2:0], ~w_trial_neg};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(QBITS - 1))
                        r_state <= ST_NORM;
                end
                ST_NORM: begin
                    if (!r_quo[QBITS-1])
                        r_ediff <= r_ediff - 10'sd1;
                    r_mant  <= w_qn[QBITS-1:2];
`ifdef FPDIV_RNE_EN
                    r_guard <= w_qn[1];
                    r_rs    <= w_qn[0] | (r_rem != '0);
`endif
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (w_e_rnd >= L_EMAX) begin
                        r_q          <= signed_inf(r_sign);
                        r_flags.of   <= 1'b1;
                        r_flags.inff <= 1'b1;
                    end else if (w_e_rnd <= 10'sd0) begin
                        r_q        <= signed_zero(r_sign);
                        r_flags.uf <= 1'b1;
                        r_flags.zf <= 1'b1;
                    end else begin
                        r_q <= {r_sign, w_e_rnd[7:0], w_mant_fin[MANT_W-2:0]};
                    end
                    r_state <= ST_FIN;
                end
                default: ;
            endcase
        end
    end

    assign o_done = (r_state == ST_FIN);
    assign o_q    = r_q;
    assign o_of   = r_flags.of;
    assign o_uf   = r_flags.uf;
    assign o_nanf = r_flags.nanf;
    assign o_inff = r_flags.inff;
    assign o_dnf  = r_flags.dnf;
    assign o_zf   = r_flags.zf;

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed cases, random operands against an
// arithmetic reference model, Start-during-DIV and mid-operation reset.
module tb_fpdiv;
    import fpdiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        done;
    logic [31:0] q;
    logic        of, uf, nanf, inff, dnf, zf;

    int n_chk  = 0;
    int n_pass = 0;

    fpdiv dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_done  (done),
        .o_q     (q),
        .o_of    (of),
        .o_uf    (uf),
        .o_nanf  (nanf),
        .o_inff  (inff),
        .o_dnf   (dnf),
        .o_zf    (zf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Flag vector order: {of, uf, nanf, inff, dnf, zf}
    function automatic void ref_div(input logic [31:0] ra, input logic [31:0] rb,
                                    output logic [31:0] rq, output logic [5:0] rf,
                                    output int rlat);
        int    ea, eb, e;
        logic  s, dn, az, bz, ai, bi, an, bn;
        longint num, den, qq, mant;
        logic  st, g, rs;
        ea = int'(ra[30:23]);
        eb = int'(rb[30:23]);
        s  = ra[31] ^ rb[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (ra[22:0] == 0);
        bi = (eb == 255) && (rb[22:0] == 0);
        an = (ea == 255) && (ra[22:0] != 0);
        bn = (eb == 255) && (rb[22:0] != 0);
        dn = (az && ra[22:0] != 0) || (bz && rb[22:0] != 0);
        rf = '0;
        rf[1] = dn;
        rlat = 1;
        if (an || bn || (az && bz) || (ai && bi)) begin
            rq = 32'hFFFF_FFFF; rf[3] = 1'b1;
        end else if (ai || bz) begin
            rq = {s, 8'hFF, 23'h0}; rf[2] = 1'b1;
        end else if (az || bi) begin
            rq = {s, 31'h0}; rf[0] = 1'b1;
        end else begin
            rlat = 29;
            num = longint'({1'b1, ra[22:0]}) << 25;
            den = longint'({1'b1, rb[22:0]});
            qq  = num / den;
            st  = (num % den) != 0;
            e   = ea - eb + 127;
            if (qq < (longint'(1) << 25)) begin
                qq = qq * 2;
                e  = e - 1;
            end
            mant = qq / 4;
            g    = qq[1];
            rs   = qq[0] | st;
`ifdef FPDIV_RNE_EN
            if (g && (rs || mant[0])) mant = mant + 1;
`endif
            if (mant == (longint'(1) << 24)) begin
                mant = mant / 2;
                e    = e + 1;
            end
            if (e >= 255) begin
                rq = {s, 8'hFF, 23'h0}; rf[5] = 1'b1; rf[2] = 1'b1;
            end else if (e <= 0) begin
                rq = {s, 31'h0}; rf[4] = 1'b1; rf[0] = 1'b1;
            end else begin
                rq = {s, 8'(e), mant[22:0]};
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input int pulse_at,
                          output logic [31:0] rq, output logic [5:0] rf, output int lat);
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        chk("done_drop", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == pulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        rq = q;
        rf = {of, uf, nanf, inff, dnf, zf};
    endtask

    task automatic check_op(input string tag, input logic [31:0] ta, input logic [31:0] tb);
        logic [31:0] gq, eq;
        logic [5:0]  gf, ef;
        int          gl, el;
        ref_div(ta, tb, eq, ef, el);
        run_op(ta, tb, -1, gq, gf, gl);
        chk({tag, "_q"}, gq, eq);
        chk({tag, "_flags"}, 32'(gf), 32'(ef));
        chk({tag, "_lat"}, 32'(gl), 32'(el));
    endtask

    function automatic logic [31:0] rnd_op();
        int k;
        k = $urandom_range(0, 19);
        case (k)
            0: return {1'($urandom), 31'h0};
            1: return {1'($urandom), 8'hFF, 23'h0};
            2: return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            3: return {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        logic [31:0] gq;
        logic [5:0]  gf;
        int          gl;

        #1;
        chk("rst_q", q, 32'h0);
        chk("rst_flags", 32'({of, uf, nanf, inff, dnf, zf}), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations
        run_op(32'h40C00000, 32'h40000000, -1, gq, gf, gl);
        chk("6div2_q", gq, 32'h40400000);
        chk("6div2_flags", 32'(gf), 32'h0);
        chk("6div2_lat", 32'(gl), 32'd29);

        run_op(32'h3F800000, 32'h40400000, -1, gq, gf, gl);
`ifdef FPDIV_RNE_EN
        chk("1div3_q", gq, 32'h3EAAAAAB);
`else
        chk("1div3_q", gq, 32'h3EAAAAAA);
`endif

        run_op(32'h00000000, 32'h00000000, -1, gq, gf, gl);
        chk("0div0_q", gq, 32'hFFFFFFFF);
        chk("0div0_flags", 32'(gf), 32'b001000);
        chk("0div0_lat", 32'(gl), 32'd1);

        run_op(32'h3F800000, 32'h80000000, -1, gq, gf, gl);
        chk("1divm0_q", gq, 32'hFF800000);
        chk("1divm0_flags", 32'(gf), 32'b000100);

        run_op(32'h7F000000, 32'h3E800000, -1, gq, gf, gl);
        chk("ovf_q", gq, 32'h7F800000);
        chk("ovf_flags", 32'(gf), 32'b100100);

        run_op(32'h00800000, 32'h40000000, -1, gq, gf, gl);
        chk("unf_q", gq, 32'h00000000);
        chk("unf_flags", 32'(gf), 32'b010001);

        run_op(32'h00000001, 32'h3F800000, -1, gq, gf, gl);
        chk("den_q", gq, 32'h00000000);
        chk("den_flags", 32'(gf), 32'b000011);

        // Start pulsed while in DIV must not disturb the running operation
        run_op(32'h40C00000, 32'h40000000, 5, gq, gf, gl);
        chk("ign_q", gq, 32'h40400000);
        chk("ign_lat", 32'(gl), 32'd29);

        // Reset during DIV iteration 10
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mrst_q", q, 32'h0);
        chk("mrst_flags", 32'({of, uf, nanf, inff, dnf, zf}), 32'h0);
        chk("mrst_done", 32'(done), 32'h0);
        chk("mrst_state", 32'(dut.r_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("mrst_idle_done", 32'(done), 32'h0);
        run_op(32'h40C00000, 32'h40000000, -1, gq, gf, gl);
        chk("post_rst_q", gq, 32'h40400000);

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            check_op($sformatf("rnd%0d", i), rnd_op(), rnd_op());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
